// File: rtl/alu_pkg.sv
// Opcode and FSM state types shared by the sequential ALU core and its multiplier.
package alu_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_CMP = 2'b10,
      OP_MUL = 2'b11
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CALC = 2'b01,
      ST_HOLD = 2'b10
   } state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier: WIDTH partial-product steps, the first
// folded into the start edge, with a one-cycle done pulse after the last step.
module alu_mul_iter #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   logic [2*WIDTH-1:0] acc_reg;
   logic [2*WIDTH-1:0] mcand_reg;
   logic [WIDTH-1:0]   mplier_reg;
   logic [5:0]         cnt_reg;
   logic               busy_reg;
   logic               done_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_reg    <= '0;
         mcand_reg  <= '0;
         mplier_reg <= '0;
         cnt_reg    <= '0;
         busy_reg   <= 1'b0;
         done_reg   <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         if (start) begin
            // bit 0 of b is consumed on the load edge so done lands one edge early
            acc_reg    <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
            mcand_reg  <= {{(WIDTH-1){1'b0}}, a, 1'b0};
            mplier_reg <= b >> 1;
            cnt_reg    <= 6'd1;
            busy_reg   <= 1'b1;
         end else if (busy_reg) begin
            if (mplier_reg[0]) begin
               acc_reg <= acc_reg + mcand_reg;
            end
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            cnt_reg    <= cnt_reg + 6'd1;
            if (cnt_reg == 6'(WIDTH-1)) begin
               busy_reg <= 1'b0;
               done_reg <= 1'b1;
            end
         end
      end
   end

   assign done    = done_reg;
   assign product = acc_reg;

endmodule

// File: rtl/alu_seq_core.sv
// Sequential ALU core (ADD/SUB/CMP/MUL) with valid/ready handshakes.
// Define ALU_SEQ_MUL_EN to build the iterative multiplier; otherwise MUL reports err.
module alu_seq_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [1:0]         op,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] result,
   output logic               carry,
   output logic               ovf,
   output logic               alb,
   output logic               agb,
   output logic               aeb,
   output logic               err
);

   state_e           state_reg, state_next;
   alu_op_e          op_reg;
   logic [WIDTH-1:0] a_reg, b_reg;
   logic             alive_reg;
   logic             accept;

   logic [WIDTH:0]       sum_add, sum_sub;
   logic [2*WIDTH-1:0]   res_c;
   logic                 carry_c, ovf_c, err_c;

`ifdef ALU_SEQ_MUL_EN
   logic               mul_start;
   logic               mul_done;
   logic [2*WIDTH-1:0] mul_product;

   alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (mul_start),
      .a       (a),
      .b       (b),
      .done    (mul_done),
      .product (mul_product)
   );
`endif

   // alive_reg keeps in_ready low until the first edge after reset release
   assign in_ready  = alive_reg && (state_reg == ST_IDLE);
   assign accept    = in_valid && in_ready;
   assign out_valid = (state_reg == ST_HOLD);

   always_comb begin
      state_next = state_reg;
`ifdef ALU_SEQ_MUL_EN
      mul_start  = 1'b0;
`endif
      case (state_reg)
         ST_IDLE: begin
            if (accept) begin
               state_next = ST_HOLD;
`ifdef ALU_SEQ_MUL_EN
               if (alu_op_e'(op) == OP_MUL) begin
                  state_next = ST_CALC;
                  mul_start  = 1'b1;
               end
`endif
            end
         end
`ifdef ALU_SEQ_MUL_EN
         ST_CALC: begin
            if (mul_done) begin
               state_next = ST_HOLD;
            end
         end
`endif
         ST_HOLD: begin
            if (out_ready) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
         alive_reg <= 1'b0;
         op_reg    <= OP_ADD;
         a_reg     <= '0;
         b_reg     <= '0;
      end else begin
         state_reg <= state_next;
         alive_reg <= 1'b1;
         if (accept) begin
            op_reg <= alu_op_e'(op);
            a_reg  <= a;
            b_reg  <= b;
         end
      end
   end

   assign sum_add = {1'b0, a_reg} + {1'b0, b_reg};
   assign sum_sub = {1'b0, a_reg} + {1'b0, ~b_reg} + (WIDTH+1)'(1);

   always_comb begin
      res_c   = '0;
      carry_c = 1'b0;
      ovf_c   = 1'b0;
      err_c   = 1'b0;
      case (op_reg)
         OP_ADD: begin
            res_c   = {{WIDTH{1'b0}}, sum_add[WIDTH-1:0]};
            carry_c = sum_add[WIDTH];
            ovf_c   = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (sum_add[WIDTH-1] != a_reg[WIDTH-1]);
         end
         OP_SUB: begin
            res_c   = {{WIDTH{1'b0}}, sum_sub[WIDTH-1:0]};
            carry_c = sum_sub[WIDTH];
            ovf_c   = (a_reg[WIDTH-1] != b_reg[WIDTH-1]) && (sum_sub[WIDTH-1] != a_reg[WIDTH-1]);
         end
         OP_MUL: begin
`ifdef ALU_SEQ_MUL_EN
            res_c = mul_product;
`else
            err_c = 1'b1;
`endif
         end
         default: ;
      endcase
   end

   // everything reads zero unless a result is being presented
   assign result = out_valid ? res_c : '0;
   assign carry  = out_valid & carry_c;
   assign ovf    = out_valid & ovf_c;
   assign err    = out_valid & err_c;
   assign alb    = out_valid & (a_reg <  b_reg);
   assign agb    = out_valid & (a_reg >  b_reg);
   assign aeb    = out_valid & (a_reg == b_reg);

endmodule

// File: tb/tb_alu_seq_core.sv
// Self-checking bench for alu_seq_core (WIDTH=8): vector table through a scoreboard
// queue, plus reset and backpressure sequences. Honours ALU_SEQ_MUL_EN if defined.
module tb_alu_seq_core;

   localparam int W = 8;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           in_valid = 1'b0;
   logic           out_ready = 1'b0;
   logic [1:0]     op = 2'b00;
   logic [W-1:0]   a = '0;
   logic [W-1:0]   b = '0;
   logic           in_ready, out_valid;
   logic [2*W-1:0] result;
   logic           carry, ovf, alb, agb, aeb, err;

   alu_seq_core #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .carry     (carry),
      .ovf       (ovf),
      .alb       (alb),
      .agb       (agb),
      .aeb       (aeb),
      .err       (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]     op;
      logic [W-1:0]   a;
      logic [W-1:0]   b;
      int             hold;
      logic [2*W-1:0] res;
      logic           carry;
      logic           ovf;
      logic [2:0]     cmp;   // {alb, agb, aeb}
      logic           err;
      int             lat;
   } vec_t;

   localparam int NV = 10;
   vec_t vecs[NV];
   vec_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [1:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                               input int h, input logic [2*W-1:0] r, input logic c, input logic v,
                               input logic [2:0] cm, input logic e, input int l);
      vec_t x;
      x.op = o; x.a = va; x.b = vb; x.hold = h; x.res = r; x.carry = c;
      x.ovf = v; x.cmp = cm; x.err = e; x.lat = l;
      return x;
   endfunction

   task automatic run_op(input vec_t v, input int idx);
      vec_t       e;
      int         t;
      int         lat;
      logic       ir_seen;
      logic [2*W+5:0] snap;
      t = 0;
      while (!in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk($sformatf("v%0d_in_ready_idle", idx), in_ready, 1);
      op = v.op; a = v.a; b = v.b; in_valid = 1'b1; out_ready = 1'b0;
      sb.push_back(v);
      @(negedge clk);
      in_valid = 1'b0; op = 2'b00; a = '0; b = '0;
      lat = 1;
      ir_seen = 1'b0;
      while (!out_valid && lat < 40) begin
         if (in_ready) ir_seen = 1'b1;
         @(negedge clk);
         lat++;
      end
      if (in_ready) ir_seen = 1'b1;
      chk($sformatf("v%0d_in_ready_busy", idx), ir_seen, 0);
      chk($sformatf("v%0d_latency", idx), lat, v.lat);
      if (sb.size() == 0) begin
         chk($sformatf("v%0d_scoreboard_empty", idx), 0, 1);
         e = v;
      end else begin
         e = sb.pop_front();
      end
      chk($sformatf("v%0d_result", idx), result, e.res);
      chk($sformatf("v%0d_carry", idx), carry, e.carry);
      chk($sformatf("v%0d_ovf", idx), ovf, e.ovf);
      chk($sformatf("v%0d_cmp", idx), {alb, agb, aeb}, e.cmp);
      chk($sformatf("v%0d_err", idx), err, e.err);
      $display("op=%0d a=%02h b=%02h result=%04h c=%0b v=%0b cmp=%03b err=%0b lat=%0d",
               v.op, v.a, v.b, result, carry, ovf, {alb, agb, aeb}, err, lat);
      snap = {result, carry, ovf, alb, agb, aeb, err};
      for (int h = 0; h < v.hold; h++) begin
         @(negedge clk);
         chk($sformatf("v%0d_hold%0d", idx, h),
             {out_valid, in_ready, result, carry, ovf, alb, agb, aeb, err}, {2'b10, snap});
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk($sformatf("v%0d_release", idx), {out_valid, in_ready, result, carry, ovf, alb, agb, aeb, err},
          {2'b01, {(2*W+6){1'b0}}});
   endtask

   initial begin
      int   t;
      logic ov_seen;

      vecs[0] = mk(2'd0, 8'h3F, 8'h3E, 0, 16'h007D, 0, 0, 3'b010, 0, 1);
      vecs[1] = mk(2'd1, 8'h3F, 8'h40, 0, 16'h00FF, 0, 0, 3'b100, 0, 1);
      vecs[2] = mk(2'd1, 8'h3F, 8'h3F, 0, 16'h0000, 1, 0, 3'b001, 0, 1);
      vecs[3] = mk(2'd0, 8'h7F, 8'h01, 0, 16'h0080, 0, 1, 3'b010, 0, 1);
      vecs[4] = mk(2'd0, 8'hFF, 8'h01, 5, 16'h0000, 1, 0, 3'b010, 0, 1);
      vecs[5] = mk(2'd2, 8'h10, 8'h20, 0, 16'h0000, 0, 0, 3'b100, 0, 1);
      vecs[6] = mk(2'd1, 8'h80, 8'h01, 0, 16'h007F, 1, 1, 3'b010, 0, 1);
`ifdef ALU_SEQ_MUL_EN
      vecs[7] = mk(2'd3, 8'hFF, 8'hFF, 0, 16'hFE01, 0, 0, 3'b001, 0, W+1);
      vecs[8] = mk(2'd3, 8'h0C, 8'h0D, 2, 16'h009C, 0, 0, 3'b100, 0, W+1);
`else
      vecs[7] = mk(2'd3, 8'hFF, 8'hFF, 0, 16'h0000, 0, 0, 3'b001, 1, 1);
      vecs[8] = mk(2'd3, 8'h0C, 8'h0D, 2, 16'h0000, 0, 0, 3'b100, 1, 1);
`endif
      vecs[9] = mk(2'd2, 8'h55, 8'h55, 0, 16'h0000, 0, 0, 3'b001, 0, 1);

      // reset behaviour
      #1;
      chk("rst_outputs", {in_ready, out_valid, result, carry, ovf, alb, agb, aeb, err}, '0);
      repeat (3) @(negedge clk);
      chk("rst_in_ready_held", in_ready, 0);
      rst_n = 1'b1;
      #1;
      chk("rst_release_in_ready_before_edge", in_ready, 0);
      @(negedge clk);
      chk("rst_release_in_ready_after_edge", in_ready, 1);

      for (int i = 0; i < NV; i++) begin
         run_op(vecs[i], i);
      end

      // reset asserted four cycles into a MUL (in HOLD when the multiplier is absent)
      t = 0;
      while (!in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      op = 2'd3; a = 8'hFF; b = 8'hFF; in_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_outputs", {in_ready, out_valid, result, carry, ovf, alb, agb, aeb, err}, '0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("midrst_in_ready_before_edge", in_ready, 0);
      @(negedge clk);
      chk("midrst_in_ready_after_edge", in_ready, 1);
      out_ready = 1'b1;
      ov_seen = 1'b0;
      for (int k = 0; k < 15; k++) begin
         if (out_valid) ov_seen = 1'b1;
         @(negedge clk);
      end
      out_ready = 1'b0;
      chk("midrst_no_out_valid", ov_seen, 0);

      // recovery after the aborted operation
      run_op(vecs[0], 100);

      chk("scoreboard_drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/alu_seq_core.md
ALU_SEQ_CORE -- requirements
Module: alu_seq_core

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, operand width (legal range 4..32).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: in_valid  input  1  operation request.
REQ-005 SHALL have port: in_ready  output  1  core can accept a request.
REQ-006 SHALL have port: op  input  2  opcode: 00 ADD, 01 SUB, 10 CMP, 11 MUL.
REQ-007 SHALL have ports: a, b  input  WIDTH  unsigned operands.
REQ-008 SHALL have port: out_valid  output  1  result available.
REQ-009 SHALL have port: out_ready  input  1  consumer accepts result.
REQ-010 SHALL have port: result  output  2*WIDTH  ADD/SUB sum in low WIDTH bits with upper bits zero; MUL full product; CMP zero.
REQ-011 SHALL have ports: carry, ovf, alb, agb, aeb, err  output  1 each  status flags.

Function
REQ-012 SHALL implement FSM states: IDLE, CALC, HOLD.
REQ-013 SHALL drive in_ready high only in IDLE; a request is accepted on an edge where in_valid and in_ready are both high, and a, b and op are captured on that edge.
REQ-014 SHALL, for ADD/SUB/CMP, go IDLE->HOLD on accept and assert out_valid on the cycle after accept (latency 1).
REQ-015 SHALL, for MUL, go IDLE->CALC and run WIDTH shift-add iterations; then CALC->HOLD, with out_valid asserted exactly WIDTH+1 cycles after accept.
REQ-016 SHALL hold result and all flags stable while out_valid=1 and out_ready=0.
REQ-017 SHALL go HOLD->IDLE on an edge with out_ready=1 and drop out_valid; no new request is accepted on that edge, giving a maximum throughput of one op per 2 cycles.
REQ-018 SHALL compute ADD as a+b, with carry = bit WIDTH of the sum.
REQ-019 SHALL compute SUB as a+~b+1, with carry = carry-out (1 = no borrow); results wrap modulo 2^WIDTH.
REQ-020 SHALL set ovf to signed two's-complement overflow for ADD/SUB, and to 0 for CMP/MUL.
REQ-021 SHALL, for all ops, set alb/agb/aeb to the unsigned comparison of the captured a and b, exactly one of them high.
REQ-022 SHALL, for CMP, set result=0 and carry=0.
REQ-023 SHALL, for MUL, set result = unsigned a*b (no wrap) and carry=0.
REQ-024 SHALL, when out_valid=0, drive result and flags to zero.

Reset
REQ-025 SHALL, while rst_n=0, force state IDLE, all outputs 0 and in_ready 0, and hold internal registers cleared.
REQ-026 SHALL raise in_ready on the first clk edge after rst_n deasserts.
REQ-027 SHALL, on reset asserted mid-MUL or in HOLD, discard the operation with no out_valid pulse afterwards.

Configuration
REQ-028 SHALL, with macro ALU_SEQ_MUL_EN defined, include the MUL path per REQ-015/REQ-023, and drive err=0 for all ops.
REQ-029 SHALL, without ALU_SEQ_MUL_EN, omit the CALC state and multiplier; op=11 then completes with latency 1, result=0, err=1, and comparison flags valid.

Structure
REQ-030 SHALL place the opcode enum (ADD, SUB, CMP, MUL) and the FSM state typedef in shared package alu_pkg.
REQ-031 SHALL implement the iterative multiplier as sub-module alu_mul_iter (start/done, WIDTH-cycle shift-add), instantiated only under ALU_SEQ_MUL_EN.

Verification (WIDTH=8)
REQ-032 SHALL check ADD a=0x3F b=0x3E -> result 0x007D, carry 0, ovf 0, agb 1, out_valid 1 cycle after accept.
REQ-033 SHALL check SUB a=0x3F b=0x40 -> result 0x00FF, carry 0, alb 1; SUB a=0x3F b=0x3F -> result 0, carry 1, aeb 1.
REQ-034 SHALL check ADD a=0x7F b=0x01 -> result 0x0080, ovf 1; ADD 0xFF+0x01 -> 0x0000, carry 1.
REQ-035 SHALL check MUL a=0xFF b=0xFF -> result 0xFE01, out_valid exactly 9 cycles after accept, in_ready low throughout; without the macro -> err 1, result 0.
REQ-036 SHALL check backpressure: out_ready low for 5 cycles -> result/flags stable and in_ready low; out_ready high -> IDLE next edge.
REQ-037 SHALL check rst_n pulsed low at cycle 4 of a MUL -> outputs 0 immediately, no out_valid afterwards, in_ready high 1 edge after release.
